// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode FIFO, N_FETCH words in / N_ISSUE out per cycle; 1-cycle latency, push_ready from registered count only.
// Define INST_QUEUE_BYPASS_EN to forward pushes to decode in the same cycle when empty (0-cycle latency; flush disables it).
module inst_queue #(
  parameter int DEPTH      = 16,
  parameter int N_FETCH    = 2,
  parameter int N_ISSUE    = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [N_FETCH-1:0]              push_valid,
  input  logic [N_FETCH*DATA_WIDTH-1:0]   push_data,
  output logic                            push_ready,
  output logic [N_ISSUE-1:0]              pop_valid,
  output logic [N_ISSUE*DATA_WIDTH-1:0]   pop_data,
  input  logic [$clog2(N_ISSUE+1)-1:0]    pop_num,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            empty,
  output logic                            full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  logic          push_fire;
  logic          byp;
  logic [CW-1:0] n_push;
  logic [CW-1:0] n_avail;
  logic [CW-1:0] n_pop;
  logic [CW-1:0] n_skip;

  assign push_ready = (count_q <= CW'(DEPTH - N_FETCH));
  assign push_fire  = push_ready && push_valid[0] && !flush;

  always_comb begin
    n_push = '0;
    for (int i = 0; i < N_FETCH; i++) begin
      if (push_fire && push_valid[i]) n_push = n_push + CW'(1);
    end
  end

`ifdef INST_QUEUE_BYPASS_EN
  assign byp = push_fire && (count_q == '0);
`else
  assign byp = 1'b0;
`endif

  // Words visible to decode this cycle; pop_num beyond this is clamped.
  assign n_avail = byp ? n_push : count_q;
  assign n_pop   = (CW'(pop_num) > n_avail) ? n_avail : CW'(pop_num);
  assign n_skip  = byp ? n_pop : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Forwarded-and-consumed lanes are skipped; the rest pack from tail (== head when bypassing).
      for (int i = 0; i < N_FETCH; i++) begin
        if (push_fire && push_valid[i] && (CW'(i) >= n_skip))
          mem_d[tail_q + PW'(i) - PW'(n_skip)] = push_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      head_d  = byp ? head_q : head_q + PW'(n_pop);
      tail_d  = tail_q + PW'(n_push) - PW'(n_skip);
      count_d = count_q + n_push - n_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar g = 0; g < N_ISSUE; g++) begin : g_pop
    logic [DATA_WIDTH-1:0] stored;
    assign stored       = mem_q[head_q + PW'(g)];
    assign pop_valid[g] = (n_avail > CW'(g));
    if (g < N_FETCH) begin : g_fwd
      assign pop_data[g*DATA_WIDTH +: DATA_WIDTH] =
        byp ? push_data[g*DATA_WIDTH +: DATA_WIDTH] : stored;
    end else begin : g_mem
      assign pop_data[g*DATA_WIDTH +: DATA_WIDTH] = stored;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: vector table plus hand sequences, checked against a queue-based scoreboard.
module tb_inst_queue;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    push_valid = 2'b00;
  logic [2*DW-1:0] push_data = '0;
  logic          push_ready;
  logic [1:0]    pop_valid;
  logic [2*DW-1:0] pop_data;
  logic [1:0]    pop_num = 2'd0;
  logic [4:0]    count;
  logic          empty;
  logic          full;

  int checks = 0;
  int errors = 0;
  int clamp_seen = 0;
  logic [DW-1:0] sb[$];

  typedef struct {
    logic [1:0]  pv;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  pn;
    logic        fl;
    logic [4:0]  ec;
  } vec_t;
  vec_t tbl[7];

  inst_queue #(.DEPTH(16), .N_FETCH(2), .N_ISSUE(2), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_num(pop_num),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Protocol monitors: illegal push lane pattern, and pop requests beyond the visible words.
  always @(negedge clk) begin
    if (rst) begin
      if (((push_valid + 2'd1) & push_valid) != 2'd0) begin
        errors++;
        $display("FAIL thermo push_valid=%b not thermometer", push_valid);
      end
      if (!flush && (int'(pop_num) > $countones(pop_valid))) clamp_seen++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; push_valid = 2'b00; pop_num = 2'd0; flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic step(input logic [1:0] pv, input logic [63:0] d0, input logic [63:0] d1,
                      input logic [1:0] pn, input logic fl);
    int vis, npush, npop;
    logic fire, byp, rdy;
    logic [1:0] epv;
    logic [63:0] pw[2];
    logic [63:0] expd;
    push_valid = pv; push_data = {d1, d0}; pop_num = pn; flush = fl;
    pw[0] = d0; pw[1] = d1;
    rdy   = (16 - sb.size()) >= 2;
    fire  = rdy && pv[0] && !fl;
    npush = fire ? $countones(pv) : 0;
    byp   = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    byp   = fire && (sb.size() == 0);
`endif
    vis = byp ? npush : sb.size();
    #3;
    chk("count", 64'(count), 64'(sb.size()));
    chk("push_ready", 64'(push_ready), 64'(rdy));
    chk("empty", 64'(empty), 64'(sb.size() == 0));
    chk("full", 64'(full), 64'(sb.size() == 16));
    epv = 2'b00;
    for (int i = 0; i < 2; i++) epv[i] = (vis > i);
    chk("pop_valid", 64'(pop_valid), 64'(epv));
    for (int i = 0; i < 2; i++) begin
      if (vis > i) begin
        if (byp) expd = pw[i];
        else     expd = sb[i];
        chk("pop_data", pop_data[i*DW +: DW], expd);
      end
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (fire) begin
        sb.push_back(d0);
        if (pv[1]) sb.push_back(d1);
      end
      npop = (int'(pn) > vis) ? vis : int'(pn);
      repeat (npop) void'(sb.pop_front());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    tbl[0] = '{2'b11, 64'h00001000_24010001, 64'h00001004_24020002, 2'd0, 1'b0, 5'd2};
    tbl[1] = '{2'b00, 64'h0, 64'h0, 2'd2, 1'b0, 5'd0};
    tbl[2] = '{2'b01, 64'hA0A0_0001, 64'h0, 2'd0, 1'b0, 5'd1};
    tbl[3] = '{2'b11, 64'hB0B0_0002, 64'hC0C0_0003, 2'd1, 1'b0, 5'd2};
    tbl[4] = '{2'b00, 64'h0, 64'h0, 2'd1, 1'b0, 5'd1};
    tbl[5] = '{2'b01, 64'hD0D0_0004, 64'h0, 2'd2, 1'b0, 5'd1};
    tbl[6] = '{2'b00, 64'h0, 64'h0, 2'd1, 1'b0, 5'd0};

    do_reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);

    for (int k = 0; k < 7; k++) begin
      step(tbl[k].pv, tbl[k].d0, tbl[k].d1, tbl[k].pn, tbl[k].fl);
      chk("tbl_count", 64'(count), 64'(tbl[k].ec));
    end

    // Fill to full, then free space with a pop.
    for (int k = 0; k < 8; k++)
      step(2'b11, 64'h2000 + 64'(2*k), 64'h2000 + 64'(2*k+1), 2'd0, 1'b0);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_count", 64'(count), 64'd16);
    chk("full_ready", 64'(push_ready), 64'd0);
    step(2'b11, 64'hDEAD_0001, 64'hDEAD_0002, 2'd2, 1'b0);
    chk("after_pop_ready", 64'(push_ready), 64'd1);
    step(2'b01, 64'h3000, 64'h0, 2'd0, 1'b0);
    chk("cnt15_ready", 64'(push_ready), 64'd0);
    step(2'b01, 64'hDEAD_0003, 64'h0, 2'd0, 1'b0);
    repeat (8) step(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);
    chk("drained_empty", 64'(empty), 64'd1);

    // Reset in the middle of traffic discards contents.
    step(2'b11, 64'h4000, 64'h4001, 2'd0, 1'b0);
    rst = 1'b0; push_valid = 2'b11; push_data = {64'hDEAD_0004, 64'hDEAD_0005};
    @(posedge clk); #1;
    rst = 1'b1; push_valid = 2'b00;
    sb.delete();
    step(2'b00, 64'h0, 64'h0, 2'd0, 1'b0);

    // Walk head to slot 15, then push a pair that wraps to slot 0.
    for (int k = 0; k < 15; k++) begin
      step(2'b01, 64'h5000 + 64'(k), 64'h0, 2'd0, 1'b0);
      step(2'b00, 64'h0, 64'h0, 2'd1, 1'b0);
    end
    step(2'b11, 64'h0000_600F_0000_000F, 64'h0000_6000_0000_0000, 2'd0, 1'b0);
    step(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);
    chk("wrap_empty", 64'(empty), 64'd1);

    // Flush wins over same-cycle push and pop.
    step(2'b11, 64'h7000, 64'h7001, 2'd0, 1'b0);
    step(2'b11, 64'h7002, 64'h7003, 2'd0, 1'b0);
    step(2'b01, 64'h7004, 64'h0, 2'd0, 1'b0);
    chk("pre_flush_count", 64'(count), 64'd5);
    step(2'b11, 64'hDEAD_0006, 64'hDEAD_0007, 2'd2, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    step(2'b01, 64'h7100, 64'h0, 2'd0, 1'b0);
    step(2'b00, 64'h0, 64'h0, 2'd1, 1'b0);

    // Pop request larger than occupancy is clamped.
    step(2'b01, 64'h8000, 64'h0, 2'd0, 1'b0);
    c0 = clamp_seen;
    step(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);
    chk("clamp_count", 64'(count), 64'd0);
    chk("clamp_flag", 64'(clamp_seen > c0), 64'd1);

    // Push into an empty queue while popping one in the same cycle.
    step(2'b11, 64'h9000, 64'h9001, 2'd1, 1'b0);
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_count", 64'(count), 64'd1);
`else
    chk("byp_count", 64'(count), 64'd2);
`endif
    step(2'b00, 64'h0, 64'h0, 2'd2, 1'b0);
    chk("end_empty", 64'(empty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised instruction queue between inst_fetch and inst_decode; decouples fetch width from issue width for the multi-issue core.
- Accepts up to N_FETCH {pc, inst} words per cycle from the icache response path and presents up to N_ISSUE oldest words per cycle to decode.
- Flushed by branch resolution or except_req.
- Replaces the single-entry pipe_if register and generalises it in depth and channel count.

Parameters:
- DEPTH, 16, entry count; power of 2, DEPTH >= 2*max(N_FETCH, N_ISSUE).
- N_FETCH, 2, max words pushed per cycle; 1..4.
- N_ISSUE, 2, max words popped per cycle; 1..4.
- DATA_WIDTH, 64, bits per entry ({pc[31:0], inst[31:0]} by default).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets at posedge).
- flush  in  1  discard all entries; driven by resolved mispredict or except_req.
- push_valid  in  N_FETCH  per-lane valid; lanes contiguous from lane 0 (thermometer).
- push_data  in  N_FETCH*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]; lane 0 oldest.
- push_ready  out  1  1 when free slots >= N_FETCH.
- pop_valid  out  N_ISSUE  lane i valid when count > i.
- pop_data  out  N_ISSUE*DATA_WIDTH  entry head+i, lane 0 oldest.
- pop_num  in  $clog2(N_ISSUE+1)  words consumed this cycle, 0..N_ISSUE.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array; head/tail pointers of $clog2(DEPTH) bits with natural wrap modulo DEPTH; separate count register.
- Reset (rst==0): head=tail=count=0. Outputs: push_ready=1, pop_valid=0, empty=1, full=0, count=0. pop_data is don't-care, but the bench must see no X on any valid lane.
- Push fires when push_ready && push_valid[0]. n_push = popcount(push_valid). Lane i is written to slot (tail+i) mod DEPTH. tail += n_push.
- push_ready is all-or-nothing and is computed from the registered count only (DEPTH-count >= N_FETCH). It does not depend on the same-cycle pop, which avoids a combinational path from decode to fetch.
- Non-thermometer push_valid (e.g. 2'b10) is illegal; a bench assertion flags it.
- Pop: n_pop = min(pop_num, count). pop_num > count is clamped and flagged by an assertion. head += n_pop.
- pop_valid and pop_data are combinational from head, count and the array. Zero latency from storage to output; a push is visible at the outputs one cycle after it is written.
- Simultaneous push and pop in one cycle: count_next = count + n_push - n_pop. Both are always legal because push_ready excludes overflow.
- Flush has priority over push and pop in the same cycle: head=tail=count=0 next cycle, and same-cycle push data is dropped.
- Flush does not gate pop_valid in its own cycle; decode is expected to ignore lanes while flush=1.
- Full: push_ready=0 from the moment count > DEPTH-N_FETCH. A pop frees space for the following cycle.
- Empty: pop_valid=0 and pop_num is ignored.
- Wrap: a push or pop group crossing slot DEPTH-1 -> 0 is handled by modulo indexing; no bubble is inserted.
- Reset mid-operation discards all contents exactly as flush does.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and a push fires, pop_valid/pop_data for lanes 0..n_push-1 forward push_data combinationally in the same cycle.
  - Forwarded words consumed by pop_num are not retained; the unconsumed remainder is written starting at the current head.
  - Gives 0-cycle fetch-to-decode latency when the queue is empty.
  - Flush=1 disables the bypass.
- Undefined: no bypass; minimum latency is 1 cycle (written then read).

Test Plan:
- Reset and basic push/pop:
  - Stimulus: rst=0 for 2 cycles, release; push lanes {0x1000/0x24010001, 0x1004/0x24020002}; next cycle pop_num=2.
  - Response: before the pop, count=2, pop_valid=2'b11 in order; after the pop, count=0, empty=1.
- Fill to full:
  - Stimulus: DEPTH=16, push 2 per cycle for 8 cycles, no pop.
  - Response: full=1, count=16; push_ready=0 once count reaches 15 or more.
  - Then: pop_num=2 for one cycle gives push_ready=1 the following cycle.
- Wrap-around:
  - Stimulus: advance head to slot 15 (push/pop 15 singles), then push 2 words.
  - Response: the words land in slots 15 and 0 and pop in order with correct data.
- Simultaneous push/pop with flush priority:
  - Stimulus: count=5; push 2, pop 2, flush=1 in the same cycle.
  - Response: next cycle count=0, empty=1; the pushed words never appear.
- Partial pop and clamp:
  - Stimulus: count=1, pop_num=2.
  - Response: count=0 next cycle; the clamp assertion fires.
- Bypass:
  - Stimulus: with INST_QUEUE_BYPASS_EN, queue empty, push 2, pop_num=1 in the same cycle.
  - Response with the macro: lane 0 data is visible that cycle; next cycle count=1, holding word 2.
  - Response without the macro: pop_valid=0 that cycle; next cycle count=2.
